s1_xfer: RTL and testbench

S1_XFER -- requirements
Module: s1_xfer

---
 rtl/s1_xfer.sv | 148 ++++++++++++++
 tb/tb_s1_xfer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s1_xfer.sv
`timescale 1ns/1ps
// s1_xfer: reads 18 RB1 bytes, ships them bit-sliced to S2 over the sen/sd link,
// then receives 13-bit {address, data} packets back and writes them into RB1.
module s1_xfer (
  input  logic       clk,
  input  logic       rst,
  input  logic       updown,
  output logic       S1_done,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q,
  inout  wire        sen,
  inout  wire        sd
);

  localparam int         NumWords = 18;
  localparam logic [4:0] LastWord = 5'd17;
  localparam logic [4:0] RdLast   = 5'd18;
  localparam logic [4:0] TxLast   = 5'd20;
  localparam logic [4:0] RxLen    = 5'd13;
  localparam logic [4:0] RxSat    = 5'd14;

  typedef enum logic [2:0] {IDLE, RD, TX, GAP, WAIT_UP, RX, DONE} state_e;

  state_e      state_q;
  logic        done_q;
  logic        rw_q;
  logic [4:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  buf_q [NumWords];
  logic [12:0] shreg_q;
  logic [4:0]  cnt_q;
  logic [2:0]  pkt_q;

  logic [4:0]  word_idx;
  logic        tx_bit;
  logic        sen_oe;
  logic        sd_oe;

  // Packet j carries its 3-bit index, then bit j of every buffered word, word 0 first.
  always_comb begin
    word_idx = cnt_q - 5'd3;
    tx_bit   = 1'b0;
    case (cnt_q)
      5'd0:    tx_bit = pkt_q[2];
      5'd1:    tx_bit = pkt_q[1];
      5'd2:    tx_bit = pkt_q[0];
      default: tx_bit = buf_q[word_idx][pkt_q];
    endcase
  end

  assign sen_oe = (state_q == RD) || (state_q == TX) || (state_q == GAP);
  assign sd_oe  = (state_q == TX);
  assign sen    = sen_oe ? (state_q != TX) : 1'bz;
  assign sd     = sd_oe ? tx_bit : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      pkt_q   <= '0;
      // NOTE: the 18-byte buffer is plain flops, so it can be cleared here like any register.
      for (int i = 0; i < NumWords; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking everywhere; each branch below reads last cycle's values.
      rw_q <= 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (updown) begin
            state_q <= RX;
            shreg_q <= '0;
          end else begin
            state_q <= RD;
            addr_q  <= '0;
          end
        end
        RD: begin
          // RB1_Q lags the address by one cycle, so word cnt-1 lands now.
          if (cnt_q != 5'd0) buf_q[cnt_q - 5'd1] <= RB1_Q;
          if (cnt_q < LastWord) addr_q <= cnt_q + 5'd1;
          if (cnt_q == RdLast) begin
            state_q <= TX;
            cnt_q   <= '0;
            pkt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        TX: begin
          if (cnt_q == TxLast) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        GAP: begin
          if (pkt_q == 3'd7) begin
            state_q <= WAIT_UP;
          end else begin
            pkt_q   <= pkt_q + 3'd1;
            state_q <= TX;
          end
        end
        WAIT_UP: begin
          if (updown) begin
            state_q <= RX;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        RX: begin
          if (!rw_q && addr_q == LastWord) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!sen) begin
            shreg_q <= {shreg_q[11:0], sd};
            if (cnt_q != RxSat) cnt_q <= cnt_q + 5'd1;
          end else begin
            cnt_q <= '0;
            if (cnt_q == RxLen && shreg_q[12:8] <= LastWord) begin
              rw_q   <= 1'b0;
              addr_q <= shreg_q[12:8];
              data_q <= shreg_q[7:0];
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S1_done = done_q;
  assign RB1_RW  = rw_q;
  assign RB1_A   = addr_q;
  assign RB1_D   = data_q;

endmodule

// File: tb/tb_s1_xfer.sv
`timescale 1ns/1ps
// Directed bench for s1_xfer: RB1 memory model, S2 echo model and a table of
// received-packet vectors with hand-computed write/no-write outcomes.
module tb_s1_xfer;

  logic       clk = 1'b0;
  logic       rst;
  logic       updown;
  logic       S1_done;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] rb1_q;
  wire        sen;
  wire        sd;

  logic tb_sen_oe = 1'b0;
  logic tb_sen    = 1'b1;
  logic tb_sd_oe  = 1'b0;
  logic tb_sd     = 1'b1;

  assign sen = tb_sen_oe ? tb_sen : 1'bz;
  assign sd  = tb_sd_oe ? tb_sd : 1'bz;
  pullup (sen);
  pullup (sd);

  always #5 clk = ~clk;

  s1_xfer dut (
    .clk     (clk),
    .rst     (rst),
    .updown  (updown),
    .S1_done (S1_done),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_D   (RB1_D),
    .RB1_Q   (rb1_q),
    .sen     (sen),
    .sd      (sd)
  );

  // RB1 model: synchronous read, write on RB1_RW = 0; mem_cmd 1 = fill i+1, 2 = clear.
  logic [7:0] mem [32];
  logic [1:0] mem_cmd = 2'd0;
  int         wr_count = 0;

  always @(posedge clk) begin
    rb1_q <= mem[RB1_A];
    if (mem_cmd == 2'd1) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i + 1);
    end else if (mem_cmd == 2'd2) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (!RB1_RW) begin
      wr_count <= wr_count + 1;
      mem[RB1_A] <= RB1_D;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] cap_pkt [8];
  logic [20:0] exp_pkt [8];
  logic [7:0]  s2_word [18];
  logic [7:0]  v;
  bit          tx_toggle;
  int          bad_frame;
  int          wr0;

  typedef struct {
    int         nbits;
    logic [12:0] pkt;
    bit         exp_wr;
    logic [4:0] exp_a;
    logic [7:0] exp_d;
    bit         exp_done;
  } rx_vec_t;

  rx_vec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge: released lines read the pull-up, and follow a bench drive of 0.
  task automatic check_released(input string name);
    tb_sen_oe = 1'b0;
    tb_sd_oe  = 1'b0;
    #1;
    check({name, " sen pull"}, 32'(sen), 32'd1);
    check({name, " sd pull"},  32'(sd),  32'd1);
    tb_sen_oe = 1'b1; tb_sen = 1'b0;
    tb_sd_oe  = 1'b1; tb_sd  = 1'b0;
    #1;
    check({name, " sen free"}, 32'(sen), 32'd0);
    check({name, " sd free"},  32'(sd),  32'd0);
    tb_sen_oe = 1'b0;
    tb_sd_oe  = 1'b0;
  endtask

  // Capture 8 x (21 bit slots + 1 gap) starting at the next negedge (first TX cycle).
  task automatic capture_send();
    bad_frame = 0;
    for (int j = 0; j < 8; j++) begin
      for (int b = 0; b < 21; b++) begin
        @(negedge clk);
        if (tx_toggle && b == 0) updown = (j == 2 || j == 3);
        if (sen !== 1'b0) bad_frame++;
        cap_pkt[j][20 - b] = sd;
      end
      @(negedge clk);
      if (sen !== 1'b1) bad_frame++;
      tb_sd_oe = 1'b1; tb_sd = 1'b0;
      #1;
      if (sd !== 1'b0) bad_frame++;
      tb_sd_oe = 1'b0;
      #1;
      if (sd !== 1'b1) bad_frame++;
    end
  endtask

  // S2 side: nbits slots MSB first (bits above 12 padded with 1), then one sen = 1 cycle.
  task automatic send_pkt(input int nbits, input logic [12:0] pkt);
    int idx;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      idx = nbits - 1 - k;
      tb_sen_oe = 1'b1; tb_sen = 1'b0;
      tb_sd_oe  = 1'b1;
      tb_sd     = (idx < 13) ? pkt[idx] : 1'b1;
    end
    @(negedge clk);
    tb_sen   = 1'b1;
    tb_sd_oe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec[0] = '{12, 13'h05A5,           1'b0, 5'd0,  8'h00, 1'b0};
    vec[1] = '{13, {5'd5,  8'hA5},     1'b1, 5'd5,  8'hA5, 1'b0};
    vec[2] = '{13, {5'd20, 8'h3C},     1'b0, 5'd0,  8'h00, 1'b0};
    vec[3] = '{45, {5'd9,  8'h77},     1'b0, 5'd0,  8'h00, 1'b0};
    vec[4] = '{13, {5'd18, 8'h01},     1'b0, 5'd0,  8'h00, 1'b0};
    vec[5] = '{13, {5'd5,  8'h3C},     1'b1, 5'd5,  8'h3C, 1'b0};
    vec[6] = '{13, {5'd0,  8'h00},     1'b1, 5'd0,  8'h00, 1'b0};
    vec[7] = '{13, {5'd17, 8'h11},     1'b1, 5'd17, 8'h11, 1'b1};

    for (int j = 0; j < 8; j++) begin
      exp_pkt[j] = '0;
      exp_pkt[j][20:18] = 3'(j);
      for (int i = 0; i < 18; i++) begin
        v = 8'(i + 1);
        exp_pkt[j][17 - i] = v[j];
      end
    end

    // Reset state
    rst = 1'b0; updown = 1'b0; mem_cmd = 2'd1; tx_toggle = 1'b0;
    repeat (3) @(negedge clk);
    mem_cmd = 2'd0;
    check("rst S1_done", 32'(S1_done), 32'd0);
    check("rst RB1_RW",  32'(RB1_RW),  32'd1);
    check("rst RB1_A",   32'(RB1_A),   32'd0);
    check("rst RB1_D",   32'(RB1_D),   32'd0);
    check_released("rst");

    // Send phase with updown wiggled during RD and TX
    rst = 1'b1;
    tx_toggle = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      check($sformatf("rd%0d RB1_A", c), 32'(RB1_A), (c < 17) ? 32'(c) : 32'd17);
      check($sformatf("rd%0d RB1_RW", c), 32'(RB1_RW), 32'd1);
      check($sformatf("rd%0d sen", c), 32'(sen), 32'd1);
      if (c == 8)  updown = 1'b1;
      if (c == 12) updown = 1'b0;
    end
    capture_send();
    check("send framing errors", 32'(bad_frame), 32'd0);
    check("pkt0 literal", 32'(cap_pkt[0]), 32'h0002AAAA);
    for (int j = 0; j < 8; j++)
      check($sformatf("send pkt%0d", j), 32'(cap_pkt[j]), 32'(exp_pkt[j]));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("wait_up%0d RB1_RW", k), 32'(RB1_RW), 32'd1);
      check_released($sformatf("wait_up%0d", k));
    end

    // Round trip: S2 rebuilds the words from the packets and echoes them back
    for (int i = 0; i < 18; i++)
      for (int j = 0; j < 8; j++)
        s2_word[i][j] = cap_pkt[j][17 - i];
    mem_cmd = 2'd2; updown = 1'b1;
    tb_sen_oe = 1'b1; tb_sen = 1'b1;
    @(negedge clk);
    mem_cmd = 2'd0;
    wr0 = wr_count;
    for (int i = 0; i < 18; i++) send_pkt(13, {5'(i), s2_word[i]});
    @(negedge clk);
    check("rt last RB1_RW", 32'(RB1_RW), 32'd0);
    check("rt last RB1_A",  32'(RB1_A),  32'd17);
    check("rt last RB1_D",  32'(RB1_D),  32'd18);
    check("rt S1_done before", 32'(S1_done), 32'd0);
    @(negedge clk);
    check("rt S1_done after", 32'(S1_done), 32'd1);
    check("rt RB1_RW after",  32'(RB1_RW),  32'd1);
    for (int i = 0; i < 18; i++)
      check($sformatf("rt mem[%0d]", i), 32'(mem[i]), 32'(i + 1));
    check("rt write count", 32'(wr_count - wr0), 32'd18);

    // DONE ignores serial traffic
    wr0 = wr_count;
    send_pkt(13, {5'd3, 8'hFF});
    repeat (2) @(negedge clk);
    check("done no write", 32'(wr_count - wr0), 32'd0);
    check("done held", 32'(S1_done), 32'd1);
    check_released("done");

    // updown = 1 at reset release goes straight to RX, then the packet table
    @(negedge clk);
    rst = 1'b0; updown = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2 S1_done", 32'(S1_done), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rx_entry%0d RB1_A", k), 32'(RB1_A), 32'd0);
      check($sformatf("rx_entry%0d RB1_RW", k), 32'(RB1_RW), 32'd1);
      check_released($sformatf("rx_entry%0d", k));
    end
    tb_sen_oe = 1'b1; tb_sen = 1'b1;
    for (int e = 0; e < 8; e++) begin
      wr0 = wr_count;
      send_pkt(vec[e].nbits, vec[e].pkt);
      @(negedge clk);
      check($sformatf("rx%0d RB1_RW", e), 32'(RB1_RW), 32'(!vec[e].exp_wr));
      if (vec[e].exp_wr) begin
        check($sformatf("rx%0d RB1_A", e), 32'(RB1_A), 32'(vec[e].exp_a));
        check($sformatf("rx%0d RB1_D", e), 32'(RB1_D), 32'(vec[e].exp_d));
      end
      @(negedge clk);
      check($sformatf("rx%0d S1_done", e), 32'(S1_done), 32'(vec[e].exp_done));
      check($sformatf("rx%0d writes", e), 32'(wr_count - wr0), 32'(vec[e].exp_wr));
    end
    check("rx mem[5] overwrite", 32'(mem[5]),  32'h3C);
    check("rx mem[0]",           32'(mem[0]),  32'h00);
    check("rx mem[17]",          32'(mem[17]), 32'h11);

    // Reset mid-TX at packet 3, bit 10, then a full resend
    @(negedge clk);
    rst = 1'b0; updown = 1'b0; mem_cmd = 2'd1;
    tb_sen_oe = 1'b0; tb_sd_oe = 1'b0;
    repeat (2) @(negedge clk);
    mem_cmd = 2'd0;
    rst = 1'b1;
    tx_toggle = 1'b0;
    repeat (96) @(negedge clk);
    check("abort point in TX", 32'(sen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort RB1_RW",  32'(RB1_RW),  32'd1);
    check("abort S1_done", 32'(S1_done), 32'd0);
    check_released("abort");
    @(negedge clk);
    rst = 1'b1;
    repeat (19) @(negedge clk);
    capture_send();
    check("resend framing errors", 32'(bad_frame), 32'd0);
    for (int j = 0; j < 8; j++)
      check($sformatf("resend pkt%0d", j), 32'(cap_pkt[j]), 32'(exp_pkt[j]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
